mdu_ctrl: RTL and testbench

Multi-cycle multiply/divide controller for the 5-stage pipeline, sitting beside the E stage.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO issued from E and latches the operands.
- Counts out a fixed latency, then commits results to architectural HI/LO.
- Supplies HI/LO values for MFHI/MFLO.
- Drives the busy/stall request the hazard unit uses to hold MD-class instructions in D.

---
 rtl/mdu_ctrl.sv | 153 +++++++++++++++
 tb/tb_mdu_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mdu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mdu_ctrl
// Purpose  : Multi-cycle multiply/divide controller next to the E stage.
//            It latches a MULT/MULTU/DIV/DIVU result at issue, holds busy for
//            a fixed latency, then commits the result to HI/LO. It also
//            handles MTHI/MTLO and raises the MD-class stall request.
// Revision : 1.0 - initial release
// ============================================================================
module mdu_ctrl #(
   parameter int MUL_LAT = 5,
   parameter int DIV_LAT = 10,
   parameter int CNT_W   = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   input  logic        md_in_D,
   output logic        busy,
   output logic        stall_req,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam logic [2:0] OP_MTHI = 3'd4;
   localparam logic [2:0] OP_MTLO = 3'd5;

   state_t           state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic             accept;
   logic             long_op;
   logic             commit;

   logic [31:0]      pend_hi, pend_lo;
   logic             pend_dz;

   logic [63:0]      prod_s, prod_u;
   logic             div_signed, div_zero;
   logic [31:0]      num, den, q_mag, r_mag, quo, rem;
   logic [63:0]      result;

   // Starts are only honoured while idle; ops 0..3 are the long operations.
   assign accept  = start && (state == IDLE);
   assign long_op = (op <= 3'd3);
   assign commit  = (state == RUN) && (cnt == '0);

   // Multiply: a sign-extended 64-bit product gives the signed result mod 2^64.
   assign prod_s = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
   assign prod_u = {32'd0, rs_val} * {32'd0, rt_val};

   // Divide on magnitudes, then restore signs; a zero divisor is replaced by 1
   // only to keep the datapath well-defined, the result is discarded anyway.
   assign div_signed = ~op[0];
   assign div_zero   = (rt_val == 32'd0);
   assign num   = (div_signed && rs_val[31]) ? (32'd0 - rs_val) : rs_val;
   assign den   = div_zero ? 32'd1
                : ((div_signed && rt_val[31]) ? (32'd0 - rt_val) : rt_val);
   assign q_mag = num / den;
   assign r_mag = num % den;
   assign quo   = (div_signed && (rs_val[31] ^ rt_val[31])) ? (32'd0 - q_mag) : q_mag;
   assign rem   = (div_signed && rs_val[31]) ? (32'd0 - r_mag) : r_mag;

   // Select the {hi, lo} pair produced by the issuing operation.
   always_comb begin
      result = {rem, quo};
      case (op)
         3'd0:    result = prod_s;
         3'd1:    result = prod_u;
         default: result = {rem, quo};
      endcase
   end

   // State and latency counter registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   // Next-state, counter load/decrement and status outputs.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      busy     = 1'b0;
      done     = 1'b0;
      case (state)
         IDLE: begin
            if (accept && long_op) begin
               state_nx = RUN;
               cnt_nx   = op[1] ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);
            end
         end
         RUN: begin
            busy = 1'b1;
            if (cnt == '0) begin
               done     = 1'b1;
               state_nx = IDLE;
            end else begin
               cnt_nx = cnt - 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Capture the pending result at the accept edge; operands are ignored after.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pend_hi <= 32'd0;
         pend_lo <= 32'd0;
         pend_dz <= 1'b0;
      end else if (accept && long_op) begin
         pend_hi <= result[63:32];
         pend_lo <= result[31:0];
         pend_dz <= op[1] & div_zero;
      end
   end

   // Architectural HI/LO: commit at the end of the final busy cycle, or MTHI/MTLO.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hi <= 32'd0;
         lo <= 32'd0;
      end else if (commit) begin
         if (!pend_dz) begin
            hi <= pend_hi;
            lo <= pend_lo;
         end
      end else if (accept && (op == OP_MTHI)) begin
         hi <= rs_val;
      end else if (accept && (op == OP_MTLO)) begin
         lo <= rs_val;
      end
   end

   // Hold MD-class instructions in D while busy, including the issue cycle.
   assign stall_req = md_in_D & (busy | (start & long_op));

endmodule
`default_nettype wire

// File: tb/tb_mdu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdu_ctrl
// Purpose  : Self-checking bench for mdu_ctrl with an expected-result queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mdu_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  op = 3'd6;
   logic [31:0] rs_val = 32'd0;
   logic [31:0] rt_val = 32'd0;
   logic        md_in_D = 1'b0;
   logic        busy, stall_req, done;
   logic [31:0] hi, lo;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [63:0] exp_q[$];
   logic [31:0] m_hi = 32'd0;
   logic [31:0] m_lo = 32'd0;

   mdu_ctrl #(.MUL_LAT(5), .DIV_LAT(10), .CNT_W(4)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op),
      .rs_val(rs_val), .rt_val(rt_val), .md_in_D(md_in_D),
      .busy(busy), .stall_req(stall_req), .done(done), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference model for {hi, lo} after an operation, given the current HI/LO.
   function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      longint          sa, sb;
      longint unsigned ua, ub;
      int              ia, ib, q, r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'(a);
      ub = longint'(b);
      ia = a;
      ib = b;
      case (o)
         3'd0: return 64'(sa * sb);
         3'd1: return 64'(ua * ub);
         3'd2: begin
            if (b == 32'd0) return {m_hi, m_lo};
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
            q = ia / ib;
            r = ia % ib;
            return {32'(r), 32'(q)};
         end
         3'd3: begin
            if (b == 32'd0) return {m_hi, m_lo};
            return {a % b, a / b};
         end
         3'd4: return {a, m_lo};
         3'd5: return {m_hi, a};
         default: return {m_hi, m_lo};
      endcase
   endfunction

   // Issue a long op, watch the busy window, then compare the committed HI/LO.
   task automatic md_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic dd, input bit poke);
      int          n;
      int          lat;
      logic [63:0] e;
      exp_q.push_back(model(o, a, b));
      lat = (o <= 3'd1) ? 5 : 10;
      @(posedge clk); #1;
      start = 1'b1; op = o; rs_val = a; rt_val = b; md_in_D = dd;
      @(negedge clk);
      check("issue_busy", 64'(busy), 64'd0);
      check("issue_stall", 64'(stall_req), 64'(dd));
      @(posedge clk); #1;
      start = 1'b0; op = 3'd6; rs_val = ~a; rt_val = b + 32'd7;
      n = 0;
      @(negedge clk);
      while (busy && n < 40) begin
         n++;
         check("done", 64'(done), 64'(n == lat));
         check("stall_run", 64'(stall_req), 64'(dd));
         if (poke && n == 2) begin
            start = 1'b1; op = 3'd0; rs_val = 32'd3; rt_val = 32'd3;
         end else begin
            start = 1'b0; op = 3'd6;
         end
         @(negedge clk);
      end
      start = 1'b0; op = 3'd6;
      check("latency", 64'(n), 64'(lat));
      check("stall_idle", 64'(stall_req), 64'd0);
      e = exp_q.pop_front();
      check("hi", 64'(hi), 64'(e[63:32]));
      check("lo", 64'(lo), 64'(e[31:0]));
      m_hi = e[63:32];
      m_lo = e[31:0];
      md_in_D = 1'b0;
   endtask

   // Issue MTHI/MTLO: no busy cycles, register updates at the issue edge.
   task automatic mt_op(input logic [2:0] o, input logic [31:0] a);
      logic [63:0] e;
      exp_q.push_back(model(o, a, 32'd0));
      @(posedge clk); #1;
      start = 1'b1; op = o; rs_val = a;
      @(negedge clk);
      check("mt_busy0", 64'(busy), 64'd0);
      @(posedge clk); #1;
      start = 1'b0; op = 3'd6;
      @(negedge clk);
      e = exp_q.pop_front();
      check("mt_busy1", 64'(busy), 64'd0);
      check("mt_hi", 64'(hi), 64'(e[63:32]));
      check("mt_lo", 64'(lo), 64'(e[31:0]));
      m_hi = e[63:32];
      m_lo = e[31:0];
   endtask

   initial begin
      logic [2:0]  ro;
      logic [31:0] ra, rb;

      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_hilo", {hi, lo}, 64'd0);

      // Multiply signed/unsigned, with and without an MD instruction in D.
      md_op(3'd0, 32'hFFFF_FFFE, 32'd3, 1'b1, 1'b0);
      md_op(3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0);
      // Divide signed/unsigned.
      md_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
      md_op(3'd3, 32'd7, 32'd2, 1'b0, 1'b0);
      // Divide by zero leaves HI/LO untouched; then the overflow case.
      mt_op(3'd4, 32'h0000_1234);
      mt_op(3'd5, 32'h0000_5678);
      md_op(3'd2, 32'h0000_0064, 32'd0, 1'b1, 1'b0);
      md_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
      // MTHI, then a start poked in mid-RUN must be ignored.
      mt_op(3'd4, 32'hAAAA_5555);
      md_op(3'd3, 32'd100, 32'd7, 1'b1, 1'b1);
      // No-op opcodes change nothing.
      @(posedge clk); #1 start = 1'b1; op = 3'd7; rs_val = 32'hDEAD_BEEF;
      @(negedge clk);
      check("noop_busy", 64'(busy), 64'd0);
      @(posedge clk); #1 start = 1'b0; op = 3'd6;
      @(negedge clk);
      check("noop_hilo", {hi, lo}, {m_hi, m_lo});

      // Random long ops against the model.
      for (int i = 0; i < 8; i++) begin
         ro = 3'($urandom_range(0, 3));
         ra = $urandom;
         rb = $urandom;
         if (i % 2 == 1) rb = rb >> 20;
         if (rb == 32'd0) rb = 32'd5;
         if (ra == 32'h8000_0000) ra = 32'h7FFF_FFFF;
         md_op(ro, ra, rb, 1'(i % 2), 1'b0);
      end

      // Asynchronous reset two cycles into a MULT: result must be dropped.
      @(posedge clk); #1;
      start = 1'b1; op = 3'd0; rs_val = 32'd9; rt_val = 32'd9;
      @(posedge clk); #1;
      start = 1'b0; op = 3'd6;
      @(posedge clk);
      @(posedge clk); #3;
      check("pre_rst_busy", 64'(busy), 64'd1);
      reset = 1'b0;
      #1;
      check("arst_busy", 64'(busy), 64'd0);
      check("arst_hilo", {hi, lo}, 64'd0);
      @(negedge clk);
      reset = 1'b1;
      m_hi = 32'd0;
      m_lo = 32'd0;
      repeat (12) begin
         @(negedge clk);
         check("post_rst_busy", 64'(busy), 64'd0);
         check("post_rst_done", 64'(done), 64'd0);
      end
      check("post_rst_hilo", {hi, lo}, 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
